bmc_soft_pipe: RTL and testbench

//  Parametrised branch-metric unit for the Viterbi decoder front end; generalises the fixed rate-1/2

---
 rtl/bmc_soft_pipe.sv | 131 +++++++++++++
 tb/tb_bmc_soft_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe -- soft-decision branch-metric unit for rate-1/N_OUT codes.
//
// For every accepted symbol, computes the metric of each of the 2^N_OUT expected
// codewords and the index of the smallest one. Two registered stages with
// valid/ready flow control.
//   S1: per-output distances to an expected '0' (x) and an expected '1' (MAX-x)
//   S2: per-codeword sums and the argmin (ties go to the lowest codeword index)
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake for rx_sym
//   rx_sym              N_OUT soft values, output i at [i*SOFT_W +: SOFT_W]
//   out_valid/out_ready output handshake for bm_all/best_cw
//   bm_all              metric of codeword c at [c*BM_W +: BM_W]
//   best_cw             index of the minimum metric
//   erase               (BMC_PUNCT_EN only) per-output puncture flags, captured with rx_sym
//
// Build option: define BMC_PUNCT_EN to add the erase port.
module bmc_soft_pipe #(
    parameter int N_OUT  = 2,
    parameter int SOFT_W = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [N_OUT*SOFT_W-1:0]                    rx_sym,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [(2**N_OUT)*(SOFT_W+$clog2(N_OUT))-1:0] bm_all,
    output logic [N_OUT-1:0]                           best_cw
`ifdef BMC_PUNCT_EN
    ,
    input  logic [N_OUT-1:0]                           erase
`endif
);

    localparam int NUM_CW = 2**N_OUT;
    localparam int BM_W   = SOFT_W + $clog2(N_OUT);
    localparam logic [SOFT_W-1:0] MAXV = '1;

    logic [N_OUT-1:0]  w_erase;
    logic              w_s1_adv;
    logic              w_s2_adv;

    logic              r_s1_valid;
    logic [SOFT_W-1:0] r_d0 [N_OUT];
    logic [SOFT_W-1:0] r_d1 [N_OUT];

    logic              r_s2_valid;
    logic [NUM_CW*BM_W-1:0] r_bm_all;
    logic [N_OUT-1:0]  r_best_cw;

    logic [NUM_CW*BM_W-1:0] w_bm_all;
    logic [N_OUT-1:0]  w_best_cw;

`ifdef BMC_PUNCT_EN
    assign w_erase = erase;
`else
    assign w_erase = '0;
`endif

    // A stage may take new data when it is empty or its content leaves this cycle.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign out_valid = r_s2_valid;
    assign bm_all    = r_bm_all;
    assign best_cw   = r_best_cw;

    // Stage 1: per-output distances; an erased output contributes zero to both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                for (int unsigned i = 0; i < N_OUT; i++) begin
                    if (w_erase[i]) begin
                        r_d0[i] <= '0;
                        r_d1[i] <= '0;
                    end else begin
                        r_d0[i] <= rx_sym[i*SOFT_W +: SOFT_W];
                        r_d1[i] <= MAXV - rx_sym[i*SOFT_W +: SOFT_W];
                    end
                end
            end
        end
    end

    // Codeword sums and argmin; strict '<' keeps the lowest index on ties.
    always_comb begin
        logic [BM_W-1:0] acc;
        logic [BM_W-1:0] best_val;
        w_bm_all  = '0;
        w_best_cw = '0;
        best_val  = '1;
        acc       = '0;
        for (int unsigned c = 0; c < NUM_CW; c++) begin
            acc = '0;
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (((c >> i) & 32'd1) != 32'd0)
                    acc = acc + BM_W'(r_d1[i]);
                else
                    acc = acc + BM_W'(r_d0[i]);
            end
            w_bm_all[c*BM_W +: BM_W] = acc;
            if (c == 0 || acc < best_val) begin
                best_val  = acc;
                w_best_cw = N_OUT'(c);
            end
        end
    end

    // Stage 2: output registers; hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_bm_all   <= '0;
            r_best_cw  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_bm_all  <= w_bm_all;
                r_best_cw <= w_best_cw;
            end
        end
    end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// tb_bmc_soft_pipe -- self-checking bench for bmc_soft_pipe at default parameters.
// Reference model computes metrics straight from the codeword definition and
// tracks in-flight symbols in a queue with their acceptance edge.
module tb_bmc_soft_pipe;

    localparam int N_OUT  = 2;
    localparam int SOFT_W = 3;
    localparam int NUM_CW = 4;
    localparam int BM_W   = 4;
    localparam int MAXV   = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*SOFT_W-1:0] rx_sym;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CW*BM_W-1:0]  bm_all;
    logic [N_OUT-1:0]        best_cw;
    logic [N_OUT-1:0]        er;

    always #5 clk = ~clk;

    bmc_soft_pipe #(.N_OUT(N_OUT), .SOFT_W(SOFT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rx_sym   (rx_sym),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bm_all   (bm_all),
        .best_cw  (best_cw)
`ifdef BMC_PUNCT_EN
        ,
        .erase    (er)
`endif
    );

    typedef struct {
        logic [NUM_CW*BM_W-1:0] bm;
        logic [N_OUT-1:0]       best;
        int                     t;
    } item_t;

    item_t q[$];
    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit stall_prev = 0;
    logic [NUM_CW*BM_W-1:0] held_bm;
    logic [N_OUT-1:0]       held_best;

    function automatic item_t model(input logic [N_OUT*SOFT_W-1:0] x, input logic [N_OUT-1:0] e);
        item_t r;
        int best_s;
        r.bm = '0;
        r.best = '0;
        r.t = 0;
        best_s = 1 << 30;
        for (int c = 0; c < NUM_CW; c++) begin
            int s;
            s = 0;
            for (int i = 0; i < N_OUT; i++) begin
                int xi;
                xi = int'((x >> (i*SOFT_W)) & MAXV);
                if (!e[i]) s += ((c >> i) & 1) ? (MAXV - xi) : xi;
            end
            r.bm[c*BM_W +: BM_W] = s[BM_W-1:0];
            if (s < best_s) begin
                best_s = s;
                r.best = c[N_OUT-1:0];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // One clock: check outputs against the model, advance the edge, update the model.
    task automatic step(output bit fired);
        bit fire_in, fire_out, exp_ov;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
        exp_ov = (q.size() > 0) && (cyc >= q[0].t + 1);
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (stall_prev) begin
            chk("hold_bm", 64'(bm_all), 64'(held_bm));
            chk("hold_best", 64'(best_cw), 64'(held_best));
        end
        if (out_valid && out_ready && !rst) begin
            if (q.size() > 0) begin
                chk("bm_all", 64'(bm_all), 64'(q[0].bm));
                chk("best_cw", 64'(best_cw), 64'(q[0].best));
            end else begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end
        end
        fire_in    = in_valid && in_ready && !rst;
        fire_out   = out_valid && out_ready && !rst && (q.size() > 0);
        stall_prev = out_valid && !out_ready && !rst;
        held_bm    = bm_all;
        held_best  = best_cw;
        fired      = fire_in;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            item_t it;
            if (fire_out) void'(q.pop_front());
            if (fire_in) begin
                it = model(rx_sym, er);
                it.t = cyc;
                q.push_back(it);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit f;
        int acc;
        int budget;
        logic [N_OUT*SOFT_W-1:0] syms [8];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rx_sym = '0; er = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_bm_all", 64'(bm_all), 64'(0));
        chk("rst_best_cw", 64'(best_cw), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Directed: x1=7, x0=0 -> c0..c3 = 7,14,0,7, best 2, two-cycle latency.
        out_ready = 1'b1; in_valid = 1'b1; rx_sym = {3'd7, 3'd0};
        step(f);
        in_valid = 1'b0;
        chk("lat1_out_valid", 64'(out_valid), 64'(0));
        step(f);
        chk("d1_bm", 64'(bm_all), 64'(16'h70E7));
        chk("d1_best", 64'(best_cw), 64'(2));
        step(f);

        // Directed: x1=3, x0=4 -> c0..c3 = 7,6,8,7, best 1.
        in_valid = 1'b1; rx_sym = {3'd3, 3'd4};
        step(f);
        in_valid = 1'b0;
        step(f);
        chk("d2_bm", 64'(bm_all), 64'(16'h7867));
        chk("d2_best", 64'(best_cw), 64'(1));
        step(f);

        // Stream of 8 with consumer stalled on cycles 3..6.
        for (int i = 0; i < 8; i++) syms[i] = 6'($urandom_range(0, 63));
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            out_ready = !(k >= 3 && k <= 6);
            in_valid  = (acc < 8);
            rx_sym    = syms[acc % 8];
            step(f);
            if (f) acc++;
        end
        chk("stream_accepted", 64'(acc), 64'(8));

        // Random traffic: 100 symbols, random handshakes.
        acc = 0; budget = 0;
        while (acc < 100 && budget < 2000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            rx_sym    = 6'($urandom_range(0, 63));
`ifdef BMC_PUNCT_EN
            er        = 2'($urandom_range(0, 3));
`endif
            step(f);
            if (f) acc++;
            budget++;
        end
        chk("rand_accepted", 64'(acc), 64'(100));
        er = '0;

        // Full throughput with a ready consumer.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rx_sym = 6'($urandom_range(0, 63));
            step(f);
            chk("throughput", 64'(f), 64'(1));
        end

        // Drain.
        in_valid = 1'b0;
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            step(f);
            budget++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));

        // Reset with both stages full: nothing in flight may appear afterwards.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rx_sym = 6'($urandom_range(0, 63));
            step(f);
        end
        rst = 1'b1; in_valid = 1'b0;
        step(f);
        rst = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        out_ready = 1'b1;
        repeat (5) step(f);

`ifdef BMC_PUNCT_EN
        // Punctured output 1 -> c0..c3 = 0,7,0,7, best 0; fully erased -> all 0.
        in_valid = 1'b1; rx_sym = {3'd7, 3'd0}; er = 2'b10;
        step(f);
        rx_sym = {3'd7, 3'd0}; er = 2'b11;
        step(f);
        in_valid = 1'b0; er = 2'b00;
        chk("p1_bm", 64'(bm_all), 64'(16'h7070));
        chk("p1_best", 64'(best_cw), 64'(0));
        step(f);
        chk("p2_bm", 64'(bm_all), 64'(0));
        chk("p2_best", 64'(best_cw), 64'(0));
        step(f);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
